// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared types and default sizing for the product accumulator.
//   state_e : FSM encoding {IDLE, ACC, HOLD}
//   PW_DEF / AW_DEF / LW_DEF : default product, accumulator and run-length widths
package prod_accum_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int PW_DEF = 8;
  localparam int AW_DEF = 12;
  localparam int LW_DEF = 4;
endpackage

// File: rtl/prod_accum_add.sv
// prod_accum_add: AW+1-bit accumulate step with carry detect.
//   i_acc   [AW-1:0] current accumulator
//   i_p     [PW-1:0] product to add (zero-extended)
//   o_sum   [AW-1:0] next accumulator value
//   o_carry          carry-out of the AW-bit add
// Build option: PROD_ACCUM_SAT_EN clamps o_sum to all ones on carry;
// otherwise o_sum wraps modulo 2^AW.
module prod_accum_add #(
  parameter int PW = 8,
  parameter int AW = 12
) (
  input  logic [AW-1:0] i_acc,
  input  logic [PW-1:0] i_p,
  output logic [AW-1:0] o_sum,
  output logic          o_carry
);
  logic [AW:0] w_full;

  assign w_full  = {1'b0, i_acc} + (AW+1)'(i_p);
  assign o_carry = w_full[AW];

`ifdef PROD_ACCUM_SAT_EN
  // Once saturated the accumulator is all ones, so any later non-zero
  // product carries again and keeps it pinned for the rest of the run.
  assign o_sum = o_carry ? {AW{1'b1}} : w_full[AW-1:0];
`else
  assign o_sum = w_full[AW-1:0];
`endif
endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums a run of `len` multiplier products and presents the total
// on a valid/ready port.
//   clk, rst_n        clock, synchronous active-low reset
//   clr               synchronous abort of the current run
//   len [LW-1:0]      products per run, captured on the first product (0 -> 1)
//   p, p_valid/p_ready product input handshake
//   sum, sum_valid/sum_ready result output handshake
//   ovf               sticky carry-out flag for the run, valid with sum
// Build option: PROD_ACCUM_SAT_EN selects saturating accumulation.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [LW-1:0] len,
  input  logic [PW-1:0] p,
  input  logic          p_valid,
  output logic          p_ready,
  output logic [AW-1:0] sum,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          ovf
);
  state_e        r_state;
  logic [AW-1:0] r_acc;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_len_q;
  logic          r_ovf;
  logic          r_sum_valid;

  logic          w_accept;
  logic [LW-1:0] w_cnt_nxt;
  logic [LW-1:0] w_len_eff;
  logic [AW-1:0] w_add_sum;
  logic          w_add_carry;

  // clr masks acceptance combinationally so a product in the abort cycle is dropped
  assign p_ready   = (r_state != HOLD) & ~clr;
  assign w_accept  = p_valid & p_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_len_eff = (len == '0) ? LW'(1) : len;

  prod_accum_add #(.PW(PW), .AW(AW)) u_add (
    .i_acc   (r_acc),
    .i_p     (p),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_ovf       <= 1'b0;
      r_sum_valid <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_acc   <= AW'(p);
          r_cnt   <= LW'(1);
          r_len_q <= w_len_eff;
          r_ovf   <= 1'b0;
          if (w_len_eff == LW'(1)) begin
            r_state     <= HOLD;
            r_sum_valid <= 1'b1;
          end else begin
            r_state <= ACC;
          end
        end
        ACC: if (w_accept) begin
          r_acc <= w_add_sum;
          r_ovf <= r_ovf | w_add_carry;
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_len_q) begin
            r_state     <= HOLD;
            r_sum_valid <= 1'b1;
          end
        end
        // acc/ovf are frozen here, so sum stays stable under backpressure
        HOLD: if (sum_ready) begin
          r_state     <= IDLE;
          r_sum_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sum       = r_acc;
  assign sum_valid = r_sum_valid;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;
  logic        clk = 1'b0;
  logic        rst_n, clr, p_valid, sum_ready;
  logic [3:0]  len;
  logic [7:0]  p;
  logic        p_ready, sum_valid, ovf;
  logic [11:0] sum;

  // narrow-accumulator instance for the carry-out case
  logic        rst2_n, p2_valid, sum2_ready;
  logic [3:0]  len2;
  logic [7:0]  p2;
  logic        p2_ready, sum2_valid, ovf2;
  logic [7:0]  sum2;

  typedef struct {logic [11:0] s; logic o;} exp_t;
  exp_t q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  prod_accum dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .p(p), .p_valid(p_valid),
    .p_ready(p_ready), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .ovf(ovf)
  );

  prod_accum #(.AW(8)) dut8 (
    .clk(clk), .rst_n(rst2_n), .clr(1'b0), .len(len2), .p(p2), .p_valid(p2_valid),
    .p_ready(p2_ready), .sum(sum2), .sum_valid(sum2_valid), .sum_ready(sum2_ready),
    .ovf(ovf2)
  );

  task automatic push_exp(input logic [11:0] s, input logic o);
    exp_t e;
    e.s = s; e.o = o;
    q.push_back(e);
  endtask

  // present one product; returns 1ns after the edge that accepted it
  task automatic send_p(input logic [7:0] v);
    int n;
    p = v; p_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!p_ready && n < 50) begin @(negedge clk); n++; end
    if (!p_ready) begin
      vec_cnt++; err_cnt++;
      $display("FAIL send_p timeout: p_ready=%0b required 1", p_ready);
    end
    @(posedge clk); #1;
    p_valid = 1'b0;
  endtask

  // wait for sum_valid, check against scoreboard head, let the transfer happen
  task automatic expect_sum(input string name, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!sum_valid && waited < 50) begin @(negedge clk); waited++; end
    vec_cnt++;
    if (!sum_valid) begin
      err_cnt++;
      $display("FAIL %s timeout: sum_valid never rose", name);
    end else if (q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s unexpected sum=%0d (scoreboard empty)", name, sum);
    end else begin
      e = q.pop_front();
      if (sum !== e.s || ovf !== e.o) begin
        err_cnt++;
        $display("FAIL %s: sum=%0d ovf=%0b required sum=%0d ovf=%0b", name, sum, ovf, e.s, e.o);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0; clr = 1'b0; p_valid = 1'b0; p2_valid = 1'b0;
    sum_ready = 1'b1; sum2_ready = 1'b1; len = 4'd0; len2 = 4'd0; p = '0; p2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (sum !== 12'd0 || sum_valid !== 1'b0 || ovf !== 1'b0 || p_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset: sum=%0d sv=%0b ovf=%0b pr=%0b required 0 0 0 1", sum, sum_valid, ovf, p_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int w;
    len = 4'd4;
    push_exp(12'd10, 1'b0);
    for (int i = 1; i <= 4; i++) send_p(8'(i));
    expect_sum("basic_sum", w);
    vec_cnt++;
    if (w !== 0) begin
      err_cnt++;
      $display("FAIL basic_latency: sum_valid after %0d extra cycles required 0", w);
    end
    @(negedge clk);
    vec_cnt++;
    if (sum_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_one_cycle: sum_valid=%0b required 0", sum_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lengths();
    int w;
    len = 4'd2;
    push_exp(12'd450, 1'b0);
    send_p(8'd225); send_p(8'd225);
    expect_sum("len2_sum", w);
    len = 4'd1;
    push_exp(12'd117, 1'b0);
    send_p(8'd117);
    expect_sum("len1_sum", w);
    len = 4'd0;
    push_exp(12'd40, 1'b0);
    send_p(8'd40);
    expect_sum("len0_sum", w);
  endtask

  task automatic test_backpressure();
    int w;
    len = 4'd3; sum_ready = 1'b0;
    push_exp(12'd108, 1'b0);
    send_p(8'd6);
    len = 4'd9;  // must not affect the run in flight
    send_p(8'd12); send_p(8'd90);
    p_valid = 1'b1; p = 8'd77;  // offered but must be refused during HOLD
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (sum !== 12'd108 || sum_valid !== 1'b1 || p_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d]: sum=%0d sv=%0b pr=%0b required 108 1 0", i, sum, sum_valid, p_ready);
      end
    end
    @(posedge clk); #1;
    p_valid = 1'b0; sum_ready = 1'b1;
    expect_sum("bp_sum", w);
    @(negedge clk);
    vec_cnt++;
    if (p_ready !== 1'b1 || sum_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_release: pr=%0b sv=%0b required 1 0", p_ready, sum_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    int w;
    logic seen;
    len = 4'd4;
    send_p(8'd10); send_p(8'd20);
    clr = 1'b1; p_valid = 1'b1; p = 8'd99;
    @(negedge clk);
    vec_cnt++;
    if (p_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL clr_pready: p_ready=%0b required 0", p_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0; p_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (sum_valid) seen = 1'b1; end
    vec_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL clr_no_sum: sum_valid seen=%0b required 0", seen);
    end
    @(posedge clk); #1;
    len = 4'd2;
    push_exp(12'd10, 1'b0);
    send_p(8'd5); send_p(8'd5);
    expect_sum("clr_after_sum", w);
  endtask

  task automatic test_ovf();
    logic [7:0] exp_s;
`ifdef PROD_ACCUM_SAT_EN
    exp_s = 8'd255;
`else
    exp_s = 8'd44;
`endif
    len2 = 4'd2; p2_valid = 1'b1; p2 = 8'd200;
    @(posedge clk); #1;
    p2 = 8'd100;
    @(posedge clk); #1;
    p2_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (sum2 !== exp_s || ovf2 !== 1'b1 || sum2_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_aw8: sum=%0d ovf=%0b sv=%0b required %0d 1 1", sum2, ovf2, sum2_valid, exp_s);
    end
    @(posedge clk); #1;
    // next run must start with ovf cleared
    len2 = 4'd1; p2_valid = 1'b1; p2 = 8'd3;
    @(posedge clk); #1;
    p2_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (sum2 !== 8'd3 || ovf2 !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_clear: sum=%0d ovf=%0b required 3 0", sum2, ovf2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int w;
    len = 4'd4;
    send_p(8'd1); send_p(8'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (sum !== 12'd0 || sum_valid !== 1'b0 || ovf !== 1'b0 || p_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_acc: sum=%0d sv=%0b ovf=%0b pr=%0b required 0 0 0 1", sum, sum_valid, ovf, p_ready);
    end
    @(posedge clk); #1;
    len = 4'd2;
    push_exp(12'd7, 1'b0);
    send_p(8'd3); send_p(8'd4);
    expect_sum("rst_after_sum", w);
    // reset while holding a result
    sum_ready = 1'b0; len = 4'd1;
    send_p(8'd50);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (sum !== 12'd0 || sum_valid !== 1'b0 || ovf !== 1'b0 || p_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_hold: sum=%0d sv=%0b ovf=%0b pr=%0b required 0 0 0 1", sum, sum_valid, ovf, p_ready);
    end
    @(posedge clk); #1;
    sum_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lengths();
    test_backpressure();
    test_clr();
    test_ovf();
    test_reset_midrun();
    vec_cnt++;
    if (q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
